text_char_buffer: RTL and testbench



---
 rtl/text_pkg.sv | 16 +
 rtl/text_ram_dp.sv | 24 ++
 rtl/text_char_buffer.sv | 158 +++++++++++++++
 tb/tb_text_char_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared defaults and FSM state for the text-mode character buffer.
// Imported by the buffer top level.
package text_pkg;

   localparam int         COLS_D   = 80;
   localparam int         ROWS_D   = 60;
   localparam int         CHAR_W_D = 7;
   localparam logic [6:0] FILL_D   = 7'h20;
   localparam logic [6:0] NL_D     = 7'h0A;

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

endpackage

// File: rtl/text_ram_dp.sv
// Simple dual-port character RAM: one write port, one registered read.
// Read-first on a same-cell collision; no reset so it maps to block RAM.
module text_ram_dp #(
   parameter int DEPTH = 4800,
   parameter int W     = 7,
   parameter int AW    = 13
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_q
);

   logic [W-1:0] r_mem [DEPTH];

   // write and synchronous read in one process gives read-first
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_q <= r_mem[i_raddr];
   end

endmodule

// File: rtl/text_char_buffer.sv
// Cursor-driven text character buffer with hardware clear-screen.
// Write side runs the IDLE/CLEAR FSM; read side is a registered port.
module text_char_buffer
   import text_pkg::*;
#(
   parameter int                COLS   = COLS_D,
   parameter int                ROWS   = ROWS_D,
   parameter int                CHAR_W = CHAR_W_D,
   parameter logic [CHAR_W-1:0] FILL   = CHAR_W'(FILL_D),
   parameter logic [CHAR_W-1:0] NL     = CHAR_W'(NL_D),
   parameter int                ROW_W  = $clog2(ROWS),
   parameter int                COL_W  = $clog2(COLS),
   parameter int                ADDR_W = $clog2(ROWS*COLS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   input  logic [CHAR_W-1:0] wr_char,
   output logic              wr_ready,
   input  logic              set_valid,
   input  logic [ROW_W-1:0]  set_row,
   input  logic [COL_W-1:0]  set_col,
   input  logic              clr_req,
   output logic              busy,
   output logic [ROW_W-1:0]  cur_row,
   output logic [COL_W-1:0]  cur_col,
   input  logic [ROW_W-1:0]  rd_row,
   input  logic [COL_W-1:0]  rd_col,
   output logic [CHAR_W-1:0] rd_data
);

   localparam int                CELLS = ROWS * COLS;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS - 1);

   // row*COLS + col as a sum of shifted rows, one term per set bit of COLS
   function automatic logic [ADDR_W-1:0] cell_addr(
      input logic [ROW_W-1:0] r,
      input logic [COL_W-1:0] c
   );
      logic [ADDR_W-1:0] acc;
      acc = ADDR_W'(c);
      for (int i = 0; i < 32; i++)
         if (COLS[i]) acc = acc + (ADDR_W'(r) << i);
      return acc;
   endfunction

   state_t            r_state;
   logic [ADDR_W-1:0] r_clr_addr;
   logic [ROW_W-1:0]  r_row;
   logic [COL_W-1:0]  r_col;
   logic              r_busy;
   logic              r_wr_ready;
   logic              r_rd_ok;

   logic              w_set_ok;
   logic              w_rd_ok;
   logic              w_idle;
   logic              w_do_clr;
   logic              w_do_set;
   logic              w_do_wr;
   logic              w_is_nl;
   logic              w_last_col;
   logic [ROW_W-1:0]  w_next_row;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [CHAR_W-1:0] w_wdata;
   logic [ADDR_W-1:0] w_raddr;
   logic [CHAR_W-1:0] w_q;

   assign w_set_ok = (32'(set_row) < ROWS) && (32'(set_col) < COLS);
   assign w_rd_ok  = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);

   assign w_idle   = (r_state == IDLE);
   assign w_do_clr = w_idle && clr_req;
   assign w_do_set = w_idle && !clr_req && set_valid;
   assign w_do_wr  = w_idle && !clr_req && !set_valid
                   && wr_valid && r_wr_ready;
   assign w_is_nl  = (wr_char == NL);

   assign w_last_col = (r_col == COL_W'(COLS - 1));
   assign w_next_row = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + 1'b1;

   assign w_we    = !w_idle || (w_do_wr && !w_is_nl);
   assign w_waddr = w_idle ? cell_addr(r_row, r_col) : r_clr_addr;
   assign w_wdata = w_idle ? wr_char : FILL;
   assign w_raddr = w_rd_ok ? cell_addr(rd_row, rd_col) : '0;

   text_ram_dp #(
      .DEPTH (CELLS),
      .W     (CHAR_W),
      .AW    (ADDR_W)
   ) u_ram (
      .i_clk   (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_q     (w_q)
   );

   // write-side FSM: power-up/requested clear, cursor load, char writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= CLEAR;
         r_clr_addr <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_busy     <= 1'b1;
         r_wr_ready <= 1'b0;
      end else begin
         unique case (r_state)
            CLEAR: begin
               r_clr_addr <= r_clr_addr + 1'b1;
               if (r_clr_addr == LAST) begin
                  r_state    <= IDLE;
                  r_busy     <= 1'b0;
                  r_wr_ready <= 1'b1;
                  r_row      <= '0;
                  r_col      <= '0;
               end
            end
            IDLE: begin
               if (w_do_clr) begin
                  r_state    <= CLEAR;
                  r_clr_addr <= '0;
                  r_busy     <= 1'b1;
                  r_wr_ready <= 1'b0;
               end else if (w_do_set) begin
                  if (w_set_ok) begin
                     r_row <= set_row;
                     r_col <= set_col;
                  end
               end else if (w_do_wr) begin
                  if (w_is_nl || w_last_col) begin
                     r_col <= '0;
                     r_row <= w_next_row;
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // remember whether the registered read address was in range
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rd_ok <= 1'b0;
      else        r_rd_ok <= w_rd_ok;
   end

   assign rd_data  = r_rd_ok ? w_q : '0;
   assign wr_ready = r_wr_ready;
   assign busy     = r_busy;
   assign cur_row  = r_row;
   assign cur_col  = r_col;

endmodule

// File: tb/tb_text_char_buffer.sv
// Scoreboard bench for text_char_buffer: stimulus queues expected
// values with a due cycle, a monitor compares them after each edge.
module tb_text_char_buffer;

   localparam int K_RD  = 0;
   localparam int K_BSY = 1;
   localparam int K_RDY = 2;
   localparam int K_CUR = 3;

   typedef struct {
      int    kind;
      int    val;
      int    due;
      string name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_valid;
   logic [6:0] wr_char;
   logic       wr_ready;
   logic       set_valid;
   logic [5:0] set_row;
   logic [6:0] set_col;
   logic       clr_req;
   logic       busy;
   logic [5:0] cur_row;
   logic [6:0] cur_col;
   logic [5:0] rd_row;
   logic [6:0] rd_col;
   logic [6:0] rd_data;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   text_char_buffer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_char   (wr_char),
      .wr_ready  (wr_ready),
      .set_valid (set_valid),
      .set_row   (set_row),
      .set_col   (set_col),
      .clr_req   (clr_req),
      .busy      (busy),
      .cur_row   (cur_row),
      .cur_col   (cur_col),
      .rd_row    (rd_row),
      .rd_col    (rd_col),
      .rd_data   (rd_data)
   );

   always #5 clk = ~clk;

   function automatic int actual(input int k);
      case (k)
         K_RD:    return int'(rd_data);
         K_BSY:   return int'(busy);
         K_RDY:   return int'(wr_ready);
         default: return int'(cur_row) * 256 + int'(cur_col);
      endcase
   endfunction

   // monitor: compare every expectation that falls due after this edge
   always @(posedge clk) begin
      #1;
      cyc++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            checks++;
            if (actual(sb[i].kind) != sb[i].val) begin
               errors++;
               $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                        sb[i].name, actual(sb[i].kind), sb[i].val, cyc);
            end
            sb.delete(i);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic exp_at(input int k, input int v, input int d,
                         input string n);
      exp_t e;
      e.kind = k;
      e.val  = v;
      e.due  = cyc + d;
      e.name = n;
      sb.push_back(e);
   endtask

   task automatic rd(input int r, input int c, input int v,
                     input string n);
      rd_row = 6'(r);
      rd_col = 7'(c);
      exp_at(K_RD, v, 1, n);
      tick();
   endtask

   task automatic wr(input int ch, input int er, input int ec,
                     input string n);
      wr_valid = 1'b1;
      wr_char  = 7'(ch);
      exp_at(K_CUR, er * 256 + ec, 1, n);
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic setc(input int r, input int c, input int er,
                       input int ec, input string n);
      set_valid = 1'b1;
      set_row   = 6'(r);
      set_col   = 7'(c);
      exp_at(K_CUR, er * 256 + ec, 1, n);
      tick();
      set_valid = 1'b0;
   endtask

   task automatic release_and_clear(input string n);
      int k1;
      k1 = cyc;
      rst_n = 1'b1;
      exp_at(K_BSY, 1, 4799, {n, "_busy_last"});
      exp_at(K_BSY, 0, 4800, {n, "_busy_done"});
      exp_at(K_RDY, 1, 4800, {n, "_ready"});
      exp_at(K_CUR, 0, 4800, {n, "_cursor"});
      while (cyc < k1 + 4800) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int k0;
      rst_n     = 1'b0;
      wr_valid  = 1'b0;
      wr_char   = '0;
      set_valid = 1'b0;
      set_row   = '0;
      set_col   = '0;
      clr_req   = 1'b0;
      rd_row    = '0;
      rd_col    = '0;
      tick();
      exp_at(K_BSY, 1, 1, "rst_busy");
      exp_at(K_RDY, 0, 1, "rst_ready");
      exp_at(K_CUR, 0, 1, "rst_cursor");
      exp_at(K_RD, 0, 1, "rst_rd_data");
      tick();
      tick();
      release_and_clear("pwr_clear");

      rd(59, 79, 'h20, "fill_59_79");
      rd(0, 0, 'h20, "fill_0_0");

      wr('h41, 0, 1, "wr_A_cur");
      wr('h42, 0, 2, "wr_B_cur");
      rd(0, 1, 'h42, "rd_0_1");
      rd(0, 0, 'h41, "rd_0_0");

      setc(0, 78, 0, 78, "set_0_78");
      wr('h43, 0, 79, "wr_C_cur");
      wr('h44, 1, 0, "wr_D_cur");
      wr('h45, 1, 1, "wr_E_cur");
      rd(1, 0, 'h45, "rd_1_0");
      rd(0, 79, 'h44, "rd_0_79");
      setc(59, 79, 59, 79, "set_59_79");
      wr('h46, 0, 0, "wr_F_wrap");
      rd(59, 79, 'h46, "rd_59_79");

      setc(5, 10, 5, 10, "set_5_10");
      wr('h0A, 6, 0, "wr_NL_cur");
      rd(5, 10, 'h20, "nl_not_stored");

      // read and write the same cell in one cycle: old value returned
      rd_row = 6'd6;
      rd_col = 7'd0;
      exp_at(K_RD, 'h20, 1, "read_first");
      wr('h47, 6, 1, "wr_G_cur");
      rd(6, 0, 'h47, "rd_6_0_new");

      setc(60, 3, 6, 1, "set_row_oob");
      setc(2, 80, 6, 1, "set_col_oob");
      rd(60, 0, 0, "rd_row_oob");
      rd(0, 80, 0, "rd_col_oob");

      // clear beats set and write in the same cycle
      clr_req   = 1'b1;
      set_valid = 1'b1;
      set_row   = 6'd3;
      set_col   = 7'd3;
      wr_valid  = 1'b1;
      wr_char   = 7'h48;
      k0 = cyc;
      exp_at(K_BSY, 1, 1, "clr_busy_rise");
      exp_at(K_CUR, 6 * 256 + 1, 1, "clr_cur_hold");
      exp_at(K_BSY, 1, 4800, "clr_busy_last");
      exp_at(K_BSY, 0, 4801, "clr_busy_done");
      exp_at(K_RDY, 1, 4801, "clr_ready");
      exp_at(K_CUR, 0, 4801, "clr_cursor");
      tick();
      clr_req   = 1'b0;
      set_valid = 1'b0;
      wr_valid  = 1'b0;
      repeat (100) tick();
      wr('h5A, 6, 1, "wr_during_clr");
      while (cyc < k0 + 4801) tick();
      rd(6, 1, 'h20, "clr_char_dropped");
      rd(6, 0, 'h20, "clr_6_0");
      rd(1, 0, 'h20, "clr_1_0");
      rd(59, 79, 'h20, "clr_59_79");

      // reset in the middle of a clear
      setc(3, 3, 3, 3, "set_3_3");
      wr('h49, 3, 4, "wr_I_cur");
      clr_req = 1'b1;
      k0 = cyc;
      tick();
      clr_req = 1'b0;
      while (cyc < k0 + 1001) tick();
      rd_row = 6'd3;
      rd_col = 7'd3;
      rst_n  = 1'b0;
      exp_at(K_BSY, 1, 1, "midrst_busy");
      exp_at(K_RDY, 0, 1, "midrst_ready");
      exp_at(K_CUR, 0, 1, "midrst_cursor");
      exp_at(K_RD, 0, 1, "midrst_rd_data");
      tick();
      tick();
      release_and_clear("re_clear");
      rd(3, 3, 'h20, "reclr_3_3");
      rd(0, 0, 'h20, "reclr_0_0");

      repeat (3) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
